// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control unit and its datapath.
// The unit owns the master modport. The datapath, or a bench, owns the slave modport.
// Optional counters are present only when PERF_CNT_EN is defined.
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned ALUOP_W  = 4
);
    logic [OPCODE_W-1:0] opcode;
    logic                branchIdea;
    logic                C_dm_ready;
    logic                C_ir_load;
    logic                C_pc_write;
    logic                pcSrc;
    logic                C_offset;
    logic [ALUOP_W-1:0]  ALUop;
    logic                regWrite;
    logic                muxWriteReg;
    logic                muxWriteData;
    logic                C_reg2_aluB_mux;
    logic                C_sub_mAluInputB_L;
    logic                C_mDataMemVsAluOutput;
    logic                C_L_mux;
    logic                C_mWwriteDataA;
    logic                C_read_dm;
    logic                C_write_dm;
    logic [2:0]          state;
    logic                C_illegal;
    logic                C_mem_timeout;
`ifdef PERF_CNT_EN
    logic [31:0]         instr_retired;
    logic [31:0]         stall_cycles;
`endif

    // Control unit side
    modport master (
        input  opcode, branchIdea, C_dm_ready,
        output C_ir_load, C_pc_write, pcSrc, C_offset, ALUop,
               regWrite, muxWriteReg, muxWriteData, C_reg2_aluB_mux,
               C_sub_mAluInputB_L, C_mDataMemVsAluOutput, C_L_mux,
               C_mWwriteDataA, C_read_dm, C_write_dm, state,
               C_illegal, C_mem_timeout
`ifdef PERF_CNT_EN
        , output instr_retired, stall_cycles
`endif
    );

    // Datapath side
    modport slave (
        output opcode, branchIdea, C_dm_ready,
        input  C_ir_load, C_pc_write, pcSrc, C_offset, ALUop,
               regWrite, muxWriteReg, muxWriteData, C_reg2_aluB_mux,
               C_sub_mAluInputB_L, C_mDataMemVsAluOutput, C_L_mux,
               C_mWwriteDataA, C_read_dm, C_write_dm, state,
               C_illegal, C_mem_timeout
`ifdef PERF_CNT_EN
        , input instr_retired, stall_cycles
`endif
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit. Instructions step through FETCH, DECODE, EXEC, MEM and WB.
// A ready handshake stalls the MEM state. An illegal opcode or a memory timeout enters TRAP.
// Define PERF_CNT_EN to add the instr_retired and stall_cycles counters.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W     = 5,
    parameter int unsigned ALUOP_W      = 4,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    multicycle_control_unit_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_AR, OP_T, OP_I, OP_J, OP_M, OP_L, OP_L2, OP_Q, OP_ILL
    } opclass_t;

    state_t              stateQ, stateNext;
    logic [WAIT_W-1:0]   waitCnt, waitNext;
    logic [OPCODE_W-1:0] opQ;
    logic                memTimeoutQ, timeoutNext;
    opclass_t            curOp, decOp;

    // Map an opcode to its instruction class. Any nonzero upper bit makes the opcode illegal.
    function automatic opclass_t classify(input logic [OPCODE_W-1:0] op);
        opclass_t c;
        c = OP_ILL;
        if ((op >> 5) == '0) begin
            case (op[4:0])
                5'b00010: c = OP_AR;
                5'b01011: c = OP_T;
                5'b00001: c = OP_I;
                5'b00011: c = OP_J;
                5'b00100: c = OP_M;
                5'b00000: c = OP_L;
                5'b01100: c = OP_L2;
                5'b01000: c = OP_Q;
                default:  c = OP_ILL;
            endcase
        end
        return c;
    endfunction

    // State, wait counter, latched opcode and trap cause
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stateQ      <= FETCH;
            waitCnt     <= '0;
            opQ         <= '0;
            memTimeoutQ <= 1'b0;
        end else begin
            stateQ      <= stateNext;
            waitCnt     <= waitNext;
            memTimeoutQ <= timeoutNext;
            if (stateQ == DECODE) opQ <= bus.opcode;
        end
    end

    // Next-state and output decode; every output is forced low while RST is high
    always_comb begin
        stateNext                 = stateQ;
        waitNext                  = waitCnt;
        timeoutNext               = memTimeoutQ;
        curOp                     = classify(opQ);
        decOp                     = OP_ILL;
        bus.C_ir_load             = 1'b0;
        bus.C_pc_write            = 1'b0;
        bus.pcSrc                 = 1'b0;
        bus.C_offset              = 1'b0;
        bus.ALUop                 = '0;
        bus.regWrite              = 1'b0;
        bus.muxWriteReg           = 1'b0;
        bus.muxWriteData          = 1'b0;
        bus.C_reg2_aluB_mux       = 1'b0;
        bus.C_sub_mAluInputB_L    = 1'b0;
        bus.C_mDataMemVsAluOutput = 1'b0;
        bus.C_L_mux               = 1'b0;
        bus.C_mWwriteDataA        = 1'b0;
        bus.C_read_dm             = 1'b0;
        bus.C_write_dm            = 1'b0;
        bus.state                 = 3'd0;
        bus.C_illegal             = 1'b0;
        bus.C_mem_timeout         = 1'b0;
        if (!RST) begin
            bus.state = stateQ;
            case (stateQ)
                FETCH: begin
                    bus.C_ir_load  = 1'b1;
                    bus.C_pc_write = 1'b1;
                    stateNext      = DECODE;
                end
                DECODE: begin
                    decOp = classify(bus.opcode);
                    if (decOp == OP_Q)        stateNext = WB;
                    else if (decOp == OP_ILL) stateNext = TRAP;
                    else                      stateNext = EXEC;
                end
                EXEC: begin
                    stateNext = WB;
                    case (curOp)
                        OP_AR, OP_T: bus.ALUop = {ALUOP_W{1'b1}};
                        OP_I: begin
                            bus.ALUop           = {ALUOP_W{1'b1}};
                            bus.C_reg2_aluB_mux = 1'b1;
                        end
                        OP_J: begin
                            bus.C_pc_write = 1'b1;
                            bus.pcSrc      = 1'b1;
                            stateNext      = FETCH;
                        end
                        OP_M: begin
                            bus.C_offset   = 1'b1;
                            bus.pcSrc      = bus.branchIdea;
                            bus.C_pc_write = bus.branchIdea;
                            stateNext      = FETCH;
                        end
                        OP_L, OP_L2: begin
                            bus.C_reg2_aluB_mux    = 1'b1;
                            bus.C_sub_mAluInputB_L = 1'b1;
                            stateNext              = MEM;
                        end
                        default: stateNext = TRAP;
                    endcase
                end
                MEM: begin
                    bus.C_read_dm  = (curOp == OP_L);
                    bus.C_write_dm = (curOp == OP_L2);
                    if (bus.C_dm_ready) begin
                        waitNext  = '0;
                        stateNext = (curOp == OP_L) ? WB : FETCH;
                    end else if (waitCnt == WAIT_W'(MEM_WAIT_MAX - 1)) begin
                        waitNext    = waitCnt + 1'b1;
                        timeoutNext = 1'b1;
                        stateNext   = TRAP;
                    end else begin
                        waitNext = waitCnt + 1'b1;
                    end
                end
                WB: begin
                    bus.regWrite = 1'b1;
                    stateNext    = FETCH;
                    case (curOp)
                        OP_T: begin
                            bus.muxWriteReg  = 1'b1;
                            bus.muxWriteData = 1'b1;
                        end
                        OP_I: bus.muxWriteReg = 1'b1;
                        OP_L: begin
                            bus.C_mDataMemVsAluOutput = 1'b1;
                            bus.C_L_mux               = 1'b1;
                        end
                        OP_Q: begin
                            bus.C_L_mux        = 1'b1;
                            bus.C_mWwriteDataA = 1'b1;
                        end
                        default: ;
                    endcase
                end
                TRAP: begin
                    bus.C_illegal     = !memTimeoutQ;
                    bus.C_mem_timeout = memTimeoutQ;
                end
                default: stateNext = FETCH;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] instrQ, stallQ;

    // Count retired instructions and memory stall cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instrQ <= '0;
            stallQ <= '0;
        end else begin
            if (stateNext == FETCH && (stateQ == EXEC || stateQ == MEM || stateQ == WB))
                instrQ <= instrQ + 32'd1;
            if (stateQ == MEM && !bus.C_dm_ready)
                stallQ <= stallQ + 32'd1;
        end
    end

    assign bus.instr_retired = instrQ;
    assign bus.stall_cycles  = stallQ;
`endif
endmodule
